// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - single-clock parameterised FIFO with standard or FWFT read
module param_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_CNT   = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_CNT   = (PTR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Acceptance is judged on the registered occupancy, so a full FIFO can
  // still pop and an empty FIFO can still push in the same cycle.
  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && !rd_ok) underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is shown combinationally; zero while nothing is stored.
      assign rd_valid = !empty;
      assign rd_data  = empty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo in both read modes
module tb_param_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
  logic [8:0]    s_count, f_count;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf));

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf));

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored words plus the standard-mode read register.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf, m_rdv;
  logic [DW-1:0] m_rdd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                            input bit rd);
    bit can_rd, can_wr;
    if (r) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else if (f) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rdv = 0;
    end else begin
      can_rd = rd && (q.size() > 0);
      can_wr = w && (q.size() < DEPTH);
      if (can_rd) begin
        m_rdd = q.pop_front();
        m_rdv = 1;
      end else begin
        m_rdv = 0;
      end
      if (can_wr) q.push_back(d);
      if (w && !can_wr) m_ovf = 1;
      if (rd && !can_rd) m_unf = 1;
    end
  endtask

  task automatic compare_model();
    int n;
    n = q.size();
    check("count",       64'(s_count), 64'(n));
    check("fwft_count",  64'(f_count), 64'(n));
    check("full",        64'(s_full),  64'(n == DEPTH));
    check("empty",       64'(s_empty), 64'(n == 0));
    check("almost_full", 64'(s_af),    64'(n >= DEPTH - 4));
    check("almost_empty",64'(s_ae),    64'(n <= 4));
    check("overflow",    64'(s_ovf),   64'(m_ovf));
    check("underflow",   64'(s_unf),   64'(m_unf));
    check("fwft_flags",  64'({f_ovf, f_unf, f_full, f_empty}),
          64'({m_ovf, m_unf, n == DEPTH, n == 0}));
    check("rd_valid",    64'(s_rd_valid), 64'(m_rdv));
    check("rd_data",     64'(s_rd_data),  64'(m_rdd));
    check("fwft_valid",  64'(f_rd_valid), 64'(n > 0));
    if (n > 0) check("fwft_data", 64'(f_rd_data), 64'(q[0]));
  endtask

  task automatic cycle(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                       input bit rd);
    rst = r; flush = f; wr_en = w; wr_data = d; rd_en = rd;
    @(posedge clk);
    model_step(r, f, w, d, rd);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit            rst, flush, wr;
    logic [DW-1:0] wd;
    bit            rd;
    int            cnt;
    bit            ovf, unf, rdv;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nr, nw, cyc;
    bit dead_seen;
    bit w, r;

    tbl[0] = '{1, 0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h00};
    tbl[1] = '{0, 0, 0, 32'h00, 1, 0, 0, 1, 0, 32'h00};
    tbl[2] = '{0, 1, 0, 32'h00, 0, 0, 0, 0, 0, 32'h00};
    tbl[3] = '{0, 0, 1, 32'h11, 0, 1, 0, 0, 0, 32'h00};
    tbl[4] = '{0, 0, 1, 32'h22, 1, 1, 0, 0, 1, 32'h11};
    tbl[5] = '{0, 0, 0, 32'h00, 1, 0, 0, 0, 1, 32'h22};
    tbl[6] = '{0, 0, 0, 32'h00, 1, 0, 0, 1, 0, 32'h22};
    tbl[7] = '{0, 0, 1, 32'h33, 1, 1, 0, 1, 0, 32'h22};
    tbl[8] = '{0, 1, 1, 32'h44, 1, 0, 0, 0, 0, 32'h22};

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rst, tbl[i].flush, tbl[i].wr, tbl[i].wd, tbl[i].rd);
      check("vec_count",     64'(s_count),    64'(tbl[i].cnt));
      check("vec_overflow",  64'(s_ovf),      64'(tbl[i].ovf));
      check("vec_underflow", 64'(s_unf),      64'(tbl[i].unf));
      check("vec_rd_valid",  64'(s_rd_valid), 64'(tbl[i].rdv));
      check("vec_rd_data",   64'(s_rd_data),  64'(tbl[i].rdd));
    end

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, DW'(i), 0);
    check("full_after_256", 64'(s_full), 64'(1));
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 0, '0, 1);
      check("drain_valid", 64'(s_rd_valid), 64'(1));
      check("drain_order", 64'(s_rd_data), 64'(i));
    end
    check("empty_after_drain", 64'(s_empty), 64'(1));

    // Full with simultaneous write and read: write is dropped.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, DW'(i + 32'h100), 0);
    check("full_count", 64'(s_count), 64'(DEPTH));
    cycle(0, 0, 1, 32'hDEAD, 1);
    check("full_wr_rd_count", 64'(s_count), 64'(DEPTH - 1));
    check("full_wr_rd_ovf",   64'(s_ovf),   64'(1));
    dead_seen = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(0, 0, 0, '0, 1);
      if (s_rd_valid && s_rd_data == 32'hDEAD) dead_seen = 1;
    end
    check("dead_never_read", 64'(dead_seen), 64'(0));

    // FWFT: a word written into an empty FIFO appears the next cycle.
    cycle(0, 1, 0, '0, 0);
    cycle(0, 0, 1, 32'hA5, 0);
    check("fwft_a5_valid", 64'(f_rd_valid), 64'(1));
    check("fwft_a5_data",  64'(f_rd_data),  64'(32'hA5));
    cycle(0, 0, 0, '0, 1);
    check("fwft_pop_empty", 64'(f_empty), 64'(1));

    // Threshold sweep.
    for (int i = 0; i < 252; i++) cycle(0, 0, 1, $urandom, 0);
    check("af_at_252", 64'(s_af), 64'(1));
    cycle(0, 0, 0, '0, 1);
    check("af_at_251", 64'(s_af), 64'(0));
    for (int i = 0; i < 247; i++) cycle(0, 0, 0, '0, 1);
    check("ae_at_4", 64'(s_ae), 64'(1));
    cycle(0, 0, 1, $urandom, 0);
    check("ae_at_5", 64'(s_ae), 64'(0));

    // Wrap-around: 100 words preloaded, then 300 reads interleaved with 300 writes.
    cycle(0, 1, 0, '0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 1, $urandom, 0);
    nr = 0; nw = 0; cyc = 0;
    while ((nr < 300 || nw < 300) && cyc < 4000) begin
      w = (nw < 300) && ($urandom_range(0, 1) == 1);
      r = (nr < 300) && ($urandom_range(0, 1) == 1);
      if (w && q.size() < DEPTH) nw++;
      if (r && q.size() > 0) nr++;
      cycle(0, 0, w, $urandom, r);
      cyc++;
    end
    check("interleave_reads",  64'(nr), 64'(300));
    check("interleave_writes", 64'(nw), 64'(300));

    // Reset mid-stream.
    cycle(1, 0, 1, $urandom, 1);
    check("rst_count",    64'(s_count),    64'(0));
    check("rst_empty",    64'(s_empty),    64'(1));
    check("rst_ae",       64'(s_ae),       64'(1));
    check("rst_full",     64'(s_full),     64'(0));
    check("rst_af",       64'(s_af),       64'(0));
    check("rst_rd_valid", 64'({s_rd_valid, f_rd_valid}), 64'(0));
    check("rst_rd_data",  64'(s_rd_data),  64'(0));
    check("rst_fwft_data",64'(f_rd_data),  64'(0));
    check("rst_errors",   64'({s_ovf, s_unf, f_ovf, f_unf}), 64'(0));

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 127) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
